// File: rtl/dot_channel_seq.sv
// -----------------------------------------------------------------------------
// dot_channel_seq
// Sequencer for a single dot_channel_14 instance. Sweeps every (cs, phase)
// weight tile (cs outer, phase inner). For each tile it waits for a feature
// vector, holds ws_load/dc_load high until the channel reports ch_valid,
// captures the result into a ready/valid output stage, and then drops the
// loads for at least one cycle so the channel's inner counter clears before
// the next tile. A LOAD phase lasting TIMEOUT cycles without ch_valid parks
// the sequencer in ERR with a sticky err flag until abort or reset.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous reset, ACTIVE HIGH despite its name
//   start      in   begin a full sweep (honoured in IDLE only)
//   abort      in   synchronous return to IDLE from any busy state
//   busy       out  high whenever the sequencer is not IDLE
//   done       out  one-cycle pulse after the final result is accepted
//   err        out  sticky timeout flag, cleared by start or reset
//   d_valid    in   feature vector on the channel's d bus is stable
//   d_ready    out  one-cycle pulse: the current vector has been consumed
//   ws_load    out  channel ws_load
//   dc_load    out  channel dc_load
//   cs         out  tile select to the channel
//   phase      out  phase select to the channel
//   ch_valid   in   channel result valid
//   ch_q       in   channel result
//   res_valid  out  captured result available downstream
//   res_ready  in   downstream accepts the captured result
//   res_data   out  captured ch_q
//   res_cs     out  cs of the captured result
//   res_phase  out  phase of the captured result
// -----------------------------------------------------------------------------
`ifndef DATA_LEN
`define DATA_LEN 16
`endif

module dot_channel_seq #(
    parameter int CS_NUM    = 16,
    parameter int PHASE_NUM = 8,
    parameter int TIMEOUT   = 31
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    input  logic                 d_valid,
    output logic                 d_ready,
    output logic                 ws_load,
    output logic                 dc_load,
    output logic [3:0]           cs,
    output logic [2:0]           phase,
    input  logic                 ch_valid,
    input  logic [`DATA_LEN-1:0] ch_q,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [`DATA_LEN-1:0] res_data,
    output logic [3:0]           res_cs,
    output logic [2:0]           res_phase
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT_D = 3'd1,
        ST_LOAD   = 3'd2,
        ST_HOLD   = 3'd3,
        ST_ERR    = 3'd4
    } state_t;

    localparam logic [3:0] CS_LAST  = 4'(CS_NUM - 1);
    localparam logic [2:0] PH_LAST  = 3'(PHASE_NUM - 1);
    localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);

    state_t               state_q, state_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic                 d_ready_q, d_ready_d;
    // ws_load and dc_load always move together, so one register drives both.
    logic                 load_q, load_d;
    logic [3:0]           cs_q, cs_d;
    logic [2:0]           phase_q, phase_d;
    logic                 res_valid_q, res_valid_d;
    logic [`DATA_LEN-1:0] res_data_q, res_data_d;
    logic [3:0]           res_cs_q, res_cs_d;
    logic [2:0]           res_phase_q, res_phase_d;
    logic [7:0]           to_cnt_q, to_cnt_d;
    logic [7:0]           to_cnt_inc_s;

    // LOAD-cycle count including the cycle currently in progress.
    assign to_cnt_inc_s = to_cnt_q + 8'd1;

    // Next-state and next-output logic for the sweep FSM.
    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = err_q;
        d_ready_d   = 1'b0;
        load_d      = load_q;
        cs_d        = cs_q;
        phase_d     = phase_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_cs_d    = res_cs_q;
        res_phase_d = res_phase_q;
        to_cnt_d    = to_cnt_q;

        if (abort && (state_q != ST_IDLE)) begin
            // Abort drops everything in flight but leaves err untouched.
            state_d     = ST_IDLE;
            busy_d      = 1'b0;
            load_d      = 1'b0;
            res_valid_d = 1'b0;
            to_cnt_d    = 8'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d  = ST_WAIT_D;
                        busy_d   = 1'b1;
                        err_d    = 1'b0;
                        cs_d     = 4'd0;
                        phase_d  = 3'd0;
                        load_d   = 1'b0;
                        to_cnt_d = 8'd0;
                    end else begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                    end
                end
                ST_WAIT_D: begin
                    if (d_valid) begin
                        state_d = ST_LOAD;
                        load_d  = 1'b1;
                    end else begin
                        state_d = ST_WAIT_D;
                        load_d  = 1'b0;
                    end
                end
                ST_LOAD: begin
                    to_cnt_d = to_cnt_inc_s;
                    // A result arriving on the timeout cycle still counts.
                    if (ch_valid) begin
                        state_d     = ST_HOLD;
                        res_data_d  = ch_q;
                        res_cs_d    = cs_q;
                        res_phase_d = phase_q;
                        res_valid_d = 1'b1;
                        d_ready_d   = 1'b1;
                        load_d      = 1'b0;
                        to_cnt_d    = 8'd0;
                    end else if (to_cnt_inc_s == TO_LIMIT) begin
                        state_d  = ST_ERR;
                        err_d    = 1'b1;
                        load_d   = 1'b0;
                        to_cnt_d = 8'd0;
                    end else begin
                        state_d = ST_LOAD;
                        load_d  = 1'b1;
                    end
                end
                ST_HOLD: begin
                    // Loads stay low here so the channel recovers between tiles.
                    load_d = 1'b0;
                    if (res_valid_q && res_ready) begin
                        res_valid_d = 1'b0;
                        if (phase_q == PH_LAST) begin
                            if (cs_q == CS_LAST) begin
                                state_d = ST_IDLE;
                                busy_d  = 1'b0;
                                done_d  = 1'b1;
                            end else begin
                                state_d = ST_WAIT_D;
                                phase_d = 3'd0;
                                cs_d    = cs_q + 4'd1;
                            end
                        end else begin
                            state_d = ST_WAIT_D;
                            phase_d = phase_q + 3'd1;
                        end
                    end else begin
                        state_d = ST_HOLD;
                    end
                end
                ST_ERR: begin
                    state_d = ST_ERR;
                    busy_d  = 1'b1;
                    load_d  = 1'b0;
                end
                default: begin
                    state_d     = ST_IDLE;
                    busy_d      = 1'b0;
                    load_d      = 1'b0;
                    res_valid_d = 1'b0;
                    to_cnt_d    = 8'd0;
                end
            endcase
        end
    end

    // State and output registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            d_ready_q   <= 1'b0;
            load_q      <= 1'b0;
            cs_q        <= 4'd0;
            phase_q     <= 3'd0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_cs_q    <= 4'd0;
            res_phase_q <= 3'd0;
            to_cnt_q    <= 8'd0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            d_ready_q   <= d_ready_d;
            load_q      <= load_d;
            cs_q        <= cs_d;
            phase_q     <= phase_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_cs_q    <= res_cs_d;
            res_phase_q <= res_phase_d;
            to_cnt_q    <= to_cnt_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign d_ready   = d_ready_q;
    assign ws_load   = load_q;
    assign dc_load   = load_q;
    assign cs        = cs_q;
    assign phase     = phase_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_cs    = res_cs_q;
    assign res_phase = res_phase_q;

endmodule

// File: doc/dot_channel_seq.md
Name: dot_channel_seq

Overview:
Sequencer for one dot_channel_14 instance. It walks every (cs, phase) weight tile, drives ws_load/dc_load, and waits for the channel's valid. It captures each dot-product result into a ready/valid output stage and recovers the channel between tiles. It sits between the feature-vector source (d_valid/d_ready) and the downstream accumulator.

Parameters:
CS_NUM, 16, number of chip-select tiles; cs runs 0..CS_NUM-1 (1..16).
PHASE_NUM, 8, phases per cs; phase runs 0..PHASE_NUM-1 (1..8).
TIMEOUT, 31, maximum LOAD cycles without ch_valid before error (1..255).

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous, active-high reset (asserted = 1) despite the name.
start  in  1  begin a full sweep; sampled in IDLE only.
abort  in  1  synchronous abort; returns to IDLE from any state.
busy  out  1  high in any state except IDLE.
done  out  1  one-cycle pulse after the last result is accepted.
err  out  1  sticky timeout flag; cleared by start or reset.
d_valid  in  1  upstream feature vector on the channel's d bus is stable.
d_ready  out  1  one-cycle pulse: current vector consumed.
ws_load  out  1  to channel ws_load.
dc_load  out  1  to channel dc_load.
cs  out  4  tile select to channel.
phase  out  3  phase select to channel.
ch_valid  in  1  channel valid.
ch_q  in  `data_len  channel result.
res_valid  out  1  result available.
res_ready  in  1  downstream accepts result.
res_data  out  `data_len  captured ch_q.
res_cs  out  4  cs of captured result.
res_phase  out  3  phase of captured result.

Behaviour:
- Reset (async, rst_n=1): state IDLE. All outputs 0: busy, done, err, d_ready, ws_load, dc_load, cs, phase, res_valid, res_data, res_cs, res_phase. Timeout counter 0.
- States: IDLE, WAIT_D, LOAD, HOLD, ERR.
- IDLE: on start=1, err<=0, cs<=0, phase<=0, go to WAIT_D.
- WAIT_D: ws_load=dc_load=0. On d_valid=1, go to LOAD.
- LOAD:
  - ws_load=dc_load=1, registered, so both rise the cycle after WAIT_D sees d_valid.
  - Timeout counter increments each LOAD cycle.
  - On ch_valid=1: res_data<=ch_q, res_cs<=cs, res_phase<=phase, res_valid<=1, d_ready pulse, ws_load/dc_load<=0, counter<=0, go to HOLD.
  - If the counter reaches TIMEOUT with no ch_valid: err<=1, loads<=0, go to ERR.
  - ch_valid and timeout on the same cycle: ch_valid wins.
- HOLD: loads stay 0 (at least 1 cycle, so the channel's inner_cnt clears). When res_valid&&res_ready: res_valid<=0, then:
  - phase==PHASE_NUM-1 and cs==CS_NUM-1: done pulse, go to IDLE.
  - phase==PHASE_NUM-1 otherwise: phase<=0, cs<=cs+1, go to WAIT_D.
  - else phase<=phase+1, go to WAIT_D.
  - res_data/res_cs/res_phase stay stable while res_valid=1 and res_ready=0.
- ERR: busy=1, loads 0. Exit only by abort or reset.
- Iteration order: cs outer, phase inner. Total results = CS_NUM*PHASE_NUM. cs/phase never exceed their last index and never wrap mid-sweep.
- abort=1 in any non-IDLE state: next cycle IDLE, loads 0, res_valid 0, no done pulse. err holds its value. abort in IDLE has no effect.
- start outside IDLE is ignored. start and abort together in IDLE: start wins.
- ch_valid outside LOAD is ignored.
- Minimum per-tile period: 1 (WAIT_D) + channel latency + 1 (HOLD).

Test Plan:
- CS_NUM=2, PHASE_NUM=3; d_valid=1, res_ready=1; channel model asserts ch_valid 7 cycles after loads rise with ch_q=cs*16+phase -> 6 results in order (0,0),(0,1),(0,2),(1,0),(1,1),(1,2) with res_data 0,1,2,16,17,18; single done pulse after the sixth; busy low afterwards.
- Hold res_ready=0 for 5 cycles on the second result -> res_valid stays 1; res_data/res_cs/res_phase stable; loads stay 0; no advance until res_ready=1.
- Channel never asserts ch_valid, TIMEOUT=31 -> err=1 after 31 LOAD cycles; loads 0; busy stays 1; abort returns to IDLE with err still 1; next start clears err.
- d_valid low for 4 cycles in WAIT_D -> loads stay 0 until d_valid; exactly one d_ready pulse per result (6 total).
- rst_n pulsed asynchronously mid-LOAD (between clock edges) -> all outputs 0 immediately; state IDLE; no done.
- start re-asserted while busy, and abort in IDLE -> both ignored; the sweep completes with 6 results.
